scan_scheduler: RTL and testbench

//  Frame/row/bit-plane sequencer for the HUB75 panel path.
//  - Tells line_render which row and bit-plane to shift out, using the begin/done handshake.
//  - Drives the panel latch (lat), output enable (oe_n) and row address (panel_addr).
//  - Uses binary-coded modulation: display time for plane p is BASE_OE<<p.
//  - Shifts the next row/plane while the current one is being displayed.

---
 rtl/scan_scheduler.sv | 178 +++++++++++++++++
 tb/tb_scan_scheduler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_scheduler.sv
// HUB75 row/bit-plane sequencer: binary-coded-modulation display timing with the next
// row/plane rendered while the current one is shown; lat and an active oe_n never overlap.
module scan_scheduler #(
  parameter int ROWS      = 32,
  parameter int PWM_BITS  = 7,
  parameter int BASE_OE   = 4,
  parameter int BLANK_CYC = 2,
  parameter int LATCH_CYC = 1,
  parameter int ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1,
  parameter int PLANE_W   = (PWM_BITS > 1) ? $clog2(PWM_BITS) : 1
) (
  input  logic               clk_25MHz,
  input  logic               rst,
  input  logic               enable,
  output logic               render_begin,
  input  logic               render_done,
  output logic [ROW_W-1:0]   row_addr,
  output logic [PLANE_W-1:0] pwm_plane,
  output logic [ROW_W-1:0]   panel_addr,
  output logic               lat,
  output logic               oe_n,
  output logic               frame_start,
  output logic               busy
);

  localparam int OE_MAX  = BASE_OE << (PWM_BITS - 1);
  localparam int OE_W    = $clog2(OE_MAX) + 1;
  localparam int SEQ_MAX = (BLANK_CYC > LATCH_CYC) ? BLANK_CYC : LATCH_CYC;
  localparam int SEQ_W   = (SEQ_MAX > 1) ? $clog2(SEQ_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SHIFT,
    S_BLANK,
    S_LATCH,
    S_DISPLAY
  } state_t;

  state_t             state_q;
  logic [ROW_W-1:0]   row_q;
  logic [PLANE_W-1:0] plane_q;
  logic [ROW_W-1:0]   panel_q;
  logic [PLANE_W-1:0] shown_q;
  logic [OE_W-1:0]    oe_cnt_q;
  logic [SEQ_W-1:0]   seq_cnt_q;
  logic               render_begin_q;
  logic               lat_q;
  logic               oe_n_q;
  logic               frame_start_q;
  logic               shift_pend_q;

  logic [ROW_W-1:0]   row_d;
  logic [PLANE_W-1:0] plane_d;
  logic               wrap_d;
  logic               oe_expired;
  logic               shift_ok;
  logic [OE_W-1:0]    oe_load;

  // Next row/plane in scan order; a frame wraps after the last plane of the last row.
  always_comb begin
    plane_d = plane_q + 1'b1;
    row_d   = row_q;
    wrap_d  = 1'b0;
    if (plane_q == PLANE_W'(PWM_BITS - 1)) begin
      plane_d = '0;
      if (row_q == ROW_W'(ROWS - 1)) begin
        row_d  = '0;
        wrap_d = 1'b1;
      end else begin
        row_d = row_q + 1'b1;
      end
    end
  end

  assign oe_load    = OE_W'((BASE_OE << shown_q) - 1);
  assign oe_expired = (oe_cnt_q == '0);
  // done still reflects the previous shift in the cycle begin is asserted
  assign shift_ok   = !shift_pend_q || (render_done && !render_begin_q);

  always_ff @(posedge clk_25MHz) begin
    if (rst) begin
      state_q        <= S_IDLE;
      row_q          <= '0;
      plane_q        <= '0;
      panel_q        <= '0;
      shown_q        <= '0;
      oe_cnt_q       <= '0;
      seq_cnt_q      <= '0;
      render_begin_q <= 1'b0;
      lat_q          <= 1'b0;
      oe_n_q         <= 1'b1;
      frame_start_q  <= 1'b0;
      shift_pend_q   <= 1'b0;
    end else begin
      render_begin_q <= 1'b0;
      frame_start_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (enable) begin
            state_q        <= S_START;
            row_q          <= '0;
            plane_q        <= '0;
            render_begin_q <= 1'b1;
            frame_start_q  <= 1'b1;
          end
        end
        S_START: begin
          state_q <= S_SHIFT;
        end
        S_SHIFT: begin
          if (render_done && !render_begin_q) begin
            state_q   <= S_BLANK;
            seq_cnt_q <= SEQ_W'(BLANK_CYC - 1);
          end
        end
        S_BLANK: begin
          if (seq_cnt_q == '0) begin
            state_q   <= S_LATCH;
            lat_q     <= 1'b1;
            panel_q   <= row_q;
            shown_q   <= plane_q;
            seq_cnt_q <= SEQ_W'(LATCH_CYC - 1);
          end else begin
            seq_cnt_q <= seq_cnt_q - 1'b1;
          end
        end
        S_LATCH: begin
          if (seq_cnt_q == '0) begin
            state_q        <= S_DISPLAY;
            lat_q          <= 1'b0;
            oe_n_q         <= 1'b0;
            oe_cnt_q       <= oe_load;
            row_q          <= row_d;
            plane_q        <= plane_d;
            render_begin_q <= enable;
            shift_pend_q   <= enable;
            frame_start_q  <= enable && wrap_d;
          end else begin
            seq_cnt_q <= seq_cnt_q - 1'b1;
          end
        end
        S_DISPLAY: begin
          // Panel goes dark on expiry even if the overlapped shift is still running.
          if (oe_expired) begin
            oe_n_q <= 1'b1;
          end else begin
            oe_cnt_q <= oe_cnt_q - 1'b1;
          end
          if (oe_expired && shift_ok) begin
            shift_pend_q <= 1'b0;
            if (enable && shift_pend_q) begin
              state_q   <= S_BLANK;
              seq_cnt_q <= SEQ_W'(BLANK_CYC - 1);
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          oe_n_q  <= 1'b1;
          lat_q   <= 1'b0;
        end
      endcase
    end
  end

  assign render_begin = render_begin_q;
  assign row_addr     = row_q;
  assign pwm_plane    = plane_q;
  assign panel_addr   = panel_q;
  assign lat          = lat_q;
  assign oe_n         = oe_n_q;
  assign frame_start  = frame_start_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_scan_scheduler.sv
// Bench for scan_scheduler: line_render model with per-shift latency, event scoreboard
// (begin / latch / display-length events) checked by an independent monitor.
module tb_scan_scheduler;

  localparam int ROWS      = 4;
  localparam int PWM_BITS  = 3;
  localparam int BASE_OE   = 4;
  localparam int BLANK_CYC = 2;
  localparam int LATCH_CYC = 1;
  localparam int ROW_W     = 2;
  localparam int PLANE_W   = 2;

  localparam int K_BEG = 0;
  localparam int K_LAT = 1;
  localparam int K_OE  = 2;

  logic               clk_25MHz;
  logic               rst;
  logic               enable;
  logic               render_begin;
  logic               render_done;
  logic [ROW_W-1:0]   row_addr;
  logic [PLANE_W-1:0] pwm_plane;
  logic [ROW_W-1:0]   panel_addr;
  logic               lat;
  logic               oe_n;
  logic               frame_start;
  logic               busy;

  typedef struct {
    int kind;
    int a;
    int b;
    int c;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  int  last_begin_cyc = 0;
  int  oe_run   = 0;
  int  overlap  = 0;
  logic lat_prev = 1'b0;

  int  beg_idx = 0;
  int  cnt_m   = 0;
  logic done_m = 1'b1;

  scan_scheduler #(
    .ROWS(ROWS), .PWM_BITS(PWM_BITS), .BASE_OE(BASE_OE),
    .BLANK_CYC(BLANK_CYC), .LATCH_CYC(LATCH_CYC),
    .ROW_W(ROW_W), .PLANE_W(PLANE_W)
  ) dut (
    .clk_25MHz(clk_25MHz), .rst(rst), .enable(enable),
    .render_begin(render_begin), .render_done(render_done),
    .row_addr(row_addr), .pwm_plane(pwm_plane), .panel_addr(panel_addr),
    .lat(lat), .oe_n(oe_n), .frame_start(frame_start), .busy(busy)
  );

  initial clk_25MHz = 1'b0;
  always #20 clk_25MHz = ~clk_25MHz;

  // Shift latency per begin index: three slow shifts early in the second frame.
  function automatic int n_for(input int b);
    return (b >= 13 && b <= 15) ? 40 : 10;
  endfunction

  // line_render model: done drops the cycle after begin, rises N cycles after begin
  always @(posedge clk_25MHz) begin
    if (rst) begin
      done_m <= 1'b1;
      cnt_m  <= 0;
    end else if (render_begin) begin
      done_m  <= 1'b0;
      cnt_m   <= n_for(beg_idx) - 1;
      beg_idx <= beg_idx + 1;
    end else if (cnt_m != 0) begin
      cnt_m <= cnt_m - 1;
      if (cnt_m == 1) done_m <= 1'b1;
    end
  end
  assign render_done = done_m;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void push(input int kind, input int a, input int b, input int c);
    ev_t e;
    e.kind = kind;
    e.a    = a;
    e.b    = b;
    e.c    = c;
    exp_q.push_back(e);
  endfunction

  task automatic see(input int kind, input int a, input int b, input int c);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind=%0d a=%0d b=%0d c=%0d, expected no event",
               kind, a, b, c);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.a != a || e.b != b || e.c != c) begin
        n_fail++;
        $display("FAIL event: got kind=%0d a=%0d b=%0d c=%0d expected kind=%0d a=%0d b=%0d c=%0d",
                 kind, a, b, c, e.kind, e.a, e.b, e.c);
      end
    end
  endtask

  // Monitor: begin -> (row, plane, frame_start); latch -> (panel_addr, cycles since begin);
  // display -> length of the oe_n low run.
  always @(negedge clk_25MHz) begin
    if (rst) begin
      oe_run   = 0;
      lat_prev = 1'b0;
    end else begin
      if (lat && !lat_prev) see(K_LAT, int'(panel_addr), cyc - last_begin_cyc, 0);
      if (!oe_n) begin
        oe_run++;
      end else if (oe_run != 0) begin
        see(K_OE, oe_run, 0, 0);
        oe_run = 0;
      end
      if (render_begin) begin
        see(K_BEG, int'(row_addr), int'(pwm_plane), int'(frame_start));
        last_begin_cyc = cyc;
      end else if (frame_start) begin
        chk("frame_start_without_begin", 1, 0);
      end
      if (lat && !oe_n) overlap++;
      lat_prev = lat;
    end
    cyc++;
  end

  initial begin
    int budget;
    int lat_cnt;
    rst    = 1'b1;
    enable = 1'b0;
    repeat (3) @(posedge clk_25MHz);
    #1;
    chk("reset_oe_n", oe_n, 1);
    chk("reset_lat", lat, 0);
    chk("reset_busy", busy, 0);
    chk("reset_render_begin", render_begin, 0);
    chk("reset_frame_start", frame_start, 0);
    chk("reset_row_addr", row_addr, 0);
    chk("reset_pwm_plane", pwm_plane, 0);
    chk("reset_panel_addr", panel_addr, 0);

    // Frame 1 plus the first six slots of frame 2; enable drops on the row1/plane2 latch.
    for (int k = 0; k < 18; k++) begin
      int pl;
      int nk;
      int gap;
      int prev_l;
      pl = k % 3;
      nk = n_for(k);
      if (k == 0) begin
        push(K_BEG, 0, 0, 1);
        gap = nk + 3;
      end else begin
        prev_l = BASE_OE << ((k - 1) % 3);
        gap = (((prev_l - 1) > nk) ? (prev_l - 1) : nk) + 3;
      end
      push(K_LAT, (k / 3) % ROWS, gap, 0);
      if (k < 17) push(K_BEG, ((k + 1) / 3) % ROWS, (k + 1) % 3, ((k + 1) % 12 == 0) ? 1 : 0);
      push(K_OE, BASE_OE << pl, 0, 0);
    end

    rst    = 1'b0;
    enable = 1'b1;
    @(posedge clk_25MHz);
    #1;
    chk("start_busy", busy, 1);
    chk("start_oe_n", oe_n, 1);
    chk("start_lat", lat, 0);

    lat_cnt = 0;
    budget  = 0;
    while (lat_cnt < 18 && budget < 5000) begin
      @(posedge clk_25MHz);
      #1;
      budget++;
      if (lat) lat_cnt++;
    end
    chk("reach_latch_18", lat_cnt, 18);
    enable = 1'b0;

    budget = 0;
    while (exp_q.size() != 0 && budget < 3000) begin
      @(posedge clk_25MHz);
      #1;
      budget++;
    end
    chk("drain_after_disable", exp_q.size(), 0);
    repeat (40) @(posedge clk_25MHz);
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_oe_n", oe_n, 1);
    chk("idle_lat", lat, 0);

    // Restart, then reset in the middle of the first display.
    push(K_BEG, 0, 0, 1);
    push(K_LAT, 0, n_for(18) + 3, 0);
    push(K_BEG, 0, 1, 0);
    enable = 1'b1;
    budget = 0;
    while (oe_n && budget < 200) begin
      @(posedge clk_25MHz);
      #1;
      budget++;
    end
    chk("reach_display", oe_n, 0);
    @(posedge clk_25MHz);
    #1;
    chk("mid_display_oe_n", oe_n, 0);
    rst    = 1'b1;
    enable = 1'b0;
    @(posedge clk_25MHz);
    #1;
    chk("abort_oe_n", oe_n, 1);
    chk("abort_lat", lat, 0);
    chk("abort_busy", busy, 0);
    chk("abort_row_addr", row_addr, 0);
    chk("abort_pwm_plane", pwm_plane, 0);
    chk("abort_panel_addr", panel_addr, 0);
    chk("abort_render_begin", render_begin, 0);
    rst = 1'b0;
    repeat (10) @(posedge clk_25MHz);
    #1;
    chk("after_abort_busy", busy, 0);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("lat_oe_overlap_cycles", overlap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
